// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency with a busy
// down-counter and raises the MDU stall request for the D stage.
module mdu_e #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_d,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  localparam logic [3:0] L_MULT_CYC = 4'(MULT_CYC);
  localparam logic [3:0] L_DIV_CYC  = 4'(DIV_CYC);

  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pendHi;
  logic [31:0] r_pendLo;
  logic        r_pendWr;

  logic        w_isMul;
  logic        w_signedDiv;
  logic [63:0] w_prodS;
  logic [63:0] w_prodU;
  logic [63:0] w_prod;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [31:0] w_dividend;
  logic [31:0] w_divisor;
  logic [31:0] w_divisorNz;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_quotOut;
  logic [31:0] w_remOut;

  assign start    = en && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU);
  assign busy     = (r_cnt != 4'd0);
  assign stall_md = md_d && (start || busy);
  assign hi       = r_hi;
  assign lo       = r_lo;

  assign w_isMul     = (op == OP_MULT) || (op == OP_MULTU);
  assign w_signedDiv = (op == OP_DIV);

  assign w_prodS = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_prodU = {32'd0, a} * {32'd0, b};
  assign w_prod  = (op == OP_MULT) ? w_prodS : w_prodU;

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign w_absA      = a[31] ? (~a + 32'd1) : a;
  assign w_absB      = b[31] ? (~b + 32'd1) : b;
  assign w_dividend  = w_signedDiv ? w_absA : a;
  assign w_divisor   = w_signedDiv ? w_absB : b;
  assign w_divisorNz = (w_divisor == 32'd0) ? 32'd1 : w_divisor;
  assign w_quot      = w_dividend / w_divisorNz;
  assign w_rem       = w_dividend % w_divisorNz;
  assign w_quotOut   = (w_signedDiv && (a[31] ^ b[31])) ? (~w_quot + 32'd1) : w_quot;
  assign w_remOut    = (w_signedDiv && a[31]) ? (~w_rem + 32'd1) : w_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= 4'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_pendHi <= 32'd0;
      r_pendLo <= 32'd0;
      r_pendWr <= 1'b0;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1 && r_pendWr) begin
        r_hi <= r_pendHi;
        r_lo <= r_pendLo;
      end
    end else if (start) begin
      if (w_isMul) begin
        r_cnt    <= L_MULT_CYC;
        r_pendHi <= w_prod[63:32];
        r_pendLo <= w_prod[31:0];
        r_pendWr <= 1'b1;
      end else begin
        // Divide by zero still burns the full latency but never commits.
        r_cnt    <= L_DIV_CYC;
        r_pendHi <= w_remOut;
        r_pendLo <= w_quotOut;
        r_pendWr <= (b != 32'd0);
      end
    end else if (en && op == OP_MTHI) begin
      r_hi <= a;
    end else if (en && op == OP_MTLO) begin
      r_lo <= a;
    end
  end

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: directed literal checks plus randomized traffic
// compared every cycle against a timestamp-based behavioural model.
module tb_mdu_e;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        md_d = 1'b0;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int testsRun = 0;
  int testsFailed = 0;
  int illegalStarts = 0;

  // Model state: results land at a known cycle index rather than via a counter.
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  logic [31:0] mPendHi = 32'd0;
  logic [31:0] mPendLo = 32'd0;
  bit          mPendValid = 1'b0;
  int          cyc = 0;
  int          mDoneCyc = 0;
  logic        expStart;
  logic        expBusy;
  logic [31:0] resHi;
  logic [31:0] resLo;
  bit          resWr;

  mdu_e #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .a(a), .b(b), .md_d(md_d),
    .start(start), .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic m);
    en = e;
    op = o;
    a = x;
    b = y;
    md_d = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural results from plain 64-bit arithmetic.
  function automatic void computeResult(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                        output logic [31:0] rh, output logic [31:0] rl, output bit wr);
    longint sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    rh = 32'd0;
    rl = 32'd0;
    wr = 1'b1;
    case (o)
      3'd1: begin q = sx * sy; rh = q[63:32]; rl = q[31:0]; end
      3'd2: begin p = ux * uy; rh = p[63:32]; rl = p[31:0]; end
      3'd3: begin
        if (y == 32'd0) wr = 1'b0;
        else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
      end
      default: begin
        if (y == 32'd0) wr = 1'b0;
        else begin p = ux / uy; rl = p[31:0]; p = ux % uy; rh = p[31:0]; end
      end
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      mHi = 32'd0;
      mLo = 32'd0;
      mPendValid = 1'b0;
      mDoneCyc = 0;
    end else if (mPendValid && cyc == mDoneCyc) begin
      mHi = mPendHi;
      mLo = mPendLo;
      mPendValid = 1'b0;
    end
    expBusy = (cyc < mDoneCyc);
    expStart = en && (op >= 3'd1) && (op <= 3'd4);
    checkOutput("cmpStart", 32'(start), 32'(expStart));
    checkOutput("cmpBusy", 32'(busy), 32'(expBusy));
    checkOutput("cmpStall", 32'(stall_md), 32'(md_d && (expStart || expBusy)));
    checkOutput("cmpHi", hi, mHi);
    checkOutput("cmpLo", lo, mLo);
    if (reset) begin
      if (expStart) begin
        if (expBusy) illegalStarts++;
        else begin
          computeResult(op, a, b, resHi, resLo, resWr);
          mPendHi = resHi;
          mPendLo = resLo;
          mPendValid = resWr;
          mDoneCyc = cyc + 1 + ((op <= 3'd2) ? 5 : 10);
        end
      end else if (en && !expBusy && op == 3'd5) mHi = a;
      else if (en && !expBusy && op == 3'd6) mLo = a;
    end
  end

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] ro;
    applyStimulus(0, 3'd0, 32'd0, 32'd0, 0);
    #2;
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetHi", hi, 32'd0);
    checkOutput("resetLo", lo, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Reset in the middle of a mult must discard the result.
    applyStimulus(1, 3'd1, 32'd3, 32'd4, 0);
    tick();
    applyStimulus(0, 3'd0, 32'd0, 32'd0, 0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetHi", hi, 32'd0);
    checkOutput("midResetLo", lo, 32'd0);
    tick();
    reset = 1'b1;
    repeat (12) tick();
    checkOutput("afterResetBusy", 32'(busy), 32'd0);
    checkOutput("afterResetHi", hi, 32'd0);
    checkOutput("afterResetLo", lo, 32'd0);

    applyStimulus(1, 3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    tick();
    applyStimulus(0, 3'd0, 32'd0, 32'd0, 0);
    for (int i = 1; i <= 5; i++) begin
      checkOutput($sformatf("multBusy%0d", i), 32'(busy), 32'd1);
      checkOutput($sformatf("multHoldLo%0d", i), lo, 32'd0);
      tick();
    end
    checkOutput("multDoneBusy", 32'(busy), 32'd0);
    checkOutput("multHi", hi, 32'hFFFF_FFFF);
    checkOutput("multLo", lo, 32'hFFFF_FFFA);

    applyStimulus(1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    tick();
    applyStimulus(0, 3'd0, 32'd0, 32'd0, 0);
    repeat (5) tick();
    checkOutput("multuHi", hi, 32'hFFFF_FFFE);
    checkOutput("multuLo", lo, 32'h0000_0001);

    applyStimulus(1, 3'd3, 32'hFFFF_FFF9, 32'd2, 0);
    tick();
    applyStimulus(0, 3'd0, 32'd0, 32'd0, 0);
    repeat (9) tick();
    checkOutput("divLastBusy", 32'(busy), 32'd1);
    tick();
    checkOutput("divDoneBusy", 32'(busy), 32'd0);
    checkOutput("divLo", lo, 32'hFFFF_FFFD);
    checkOutput("divHi", hi, 32'hFFFF_FFFF);

    applyStimulus(1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    tick();
    applyStimulus(0, 3'd0, 32'd0, 32'd0, 0);
    repeat (10) tick();
    checkOutput("divOvfLo", lo, 32'h8000_0000);
    checkOutput("divOvfHi", hi, 32'd0);

    applyStimulus(1, 3'd5, 32'h11, 32'd0, 0);
    tick();
    applyStimulus(1, 3'd6, 32'h22, 32'd0, 0);
    tick();
    applyStimulus(0, 3'd0, 32'd0, 32'd0, 0);
    checkOutput("mthiHi", hi, 32'h11);
    checkOutput("mtloLo", lo, 32'h22);
    applyStimulus(1, 3'd4, 32'h1234, 32'd0, 0);
    tick();
    applyStimulus(0, 3'd0, 32'd0, 32'd0, 0);
    repeat (9) tick();
    checkOutput("divzLastBusy", 32'(busy), 32'd1);
    tick();
    checkOutput("divzDoneBusy", 32'(busy), 32'd0);
    checkOutput("divzHi", hi, 32'h11);
    checkOutput("divzLo", lo, 32'h22);

    // Stall interplay: 100/7 with a D-stage MDU instruction waiting.
    applyStimulus(1, 3'd3, 32'd100, 32'd7, 1);
    #1;
    checkOutput("stallStartCyc", 32'(stall_md), 32'd1);
    tick();
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 3'd0, 32'd0, 32'd0, 1);
      #1;
      checkOutput($sformatf("stallBusy%0d", i), 32'(stall_md), 32'd1);
      tick();
    end
    applyStimulus(1, 3'd6, 32'd5, 32'd0, 1);
    #1;
    checkOutput("stallLastBusy", 32'(busy), 32'd1);
    checkOutput("stallLast", 32'(stall_md), 32'd1);
    tick();
    applyStimulus(0, 3'd0, 32'd0, 32'd0, 1);
    #1;
    checkOutput("stallAfter", 32'(stall_md), 32'd0);
    checkOutput("stallDivLo", lo, 32'd14);
    checkOutput("stallDivHi", hi, 32'd2);
    applyStimulus(1, 3'd6, 32'd5, 32'd0, 0);
    tick();
    checkOutput("mtloReissue", lo, 32'd5);

    // Randomized traffic; mostly honours the stall, occasionally violates it.
    for (int i = 0; i < 600; i++) begin
      ro = 3'($urandom_range(0, 7));
      if (busy && $urandom_range(0, 7) != 0 && ro >= 3'd1 && ro <= 3'd6) ro = 3'd0;
      applyStimulus(1'($urandom_range(0, 3) != 0), ro, pickVal(), pickVal(), 1'($urandom_range(0, 1)));
      if (i == 300) reset = 1'b0;
      tick();
      reset = 1'b1;
    end
    applyStimulus(0, 3'd0, 32'd0, 32'd0, 0);
    for (int i = 0; i < 20 && busy; i++) tick();
    checkOutput("drainIdle", 32'(busy), 32'd0);
    tick();

    $display("[TB] note: %0d starts issued while busy were ignored", illegalStarts);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
